// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the registered ALU-control / JR decoder
// with multiply/divide sequencing.
//   - ALUOp codes from main control
//   - R-type Function codes, including JR, MULT..DIVU, MFHI, MFLO
//   - 3-bit ALU select codes
//   - HI/LO operation encodings and sequencer FSM states
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_SLT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// alu_ctrl_decode: purely combinational {alu_op, funct} decode.
// Ports:
//   alu_op   in  ALUOp from main control (codes above 2'b11 are illegal)
//   funct    in  Function field; bits above [5:0] must be zero under R-type
//   alu_ctrl out ALU select
//   jr       out jump-register
//   illegal  out undefined encoding
//   is_md    out MULT/MULTU/DIV/DIVU
//   is_mf    out MFHI/MFLO
//   md_op    out HI/LO op encoding (funct[1:0]), meaningful with is_md
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int FUNCT_W = 6
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alu_ctrl,
  output logic               jr,
  output logic               illegal,
  output logic               is_md,
  output logic               is_mf,
  output logic [1:0]         md_op
);

  logic [5:0] fn;
  logic       upper_nz;

  assign fn       = funct[5:0];
  // shift instead of slicing so the default FUNCT_W=6 build has no empty range
  assign upper_nz = |(funct >> 6);

  always_comb begin
    alu_ctrl = ALU_ADD;
    jr       = 1'b0;
    illegal  = 1'b0;
    is_md    = 1'b0;
    is_mf    = 1'b0;
    md_op    = fn[1:0];
    case (alu_op)
      ALUOP_W'(ALUOP_ADD): alu_ctrl = ALU_ADD;
      ALUOP_W'(ALUOP_SUB): alu_ctrl = ALU_SUB;
      ALUOP_W'(ALUOP_SLT): alu_ctrl = ALU_SLT;
      ALUOP_W'(ALUOP_RTYPE): begin
        if (upper_nz) begin
          illegal = 1'b1;
        end else begin
          case (fn)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_XOR:  alu_ctrl = ALU_XOR;
            FN_SLL:  alu_ctrl = ALU_SLL;
            FN_SRL:  alu_ctrl = ALU_SRL;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_JR:   jr       = 1'b1;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_md = 1'b1;
            FN_MFHI, FN_MFLO: is_mf = 1'b1;
            default: illegal  = 1'b1;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU-control / JR decoder with a valid/ready
// handshake, one-entry output register and a fixed-latency HI/LO sequencer
// that interlocks MFHI/MFLO and further HI/LO ops while busy.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       request handshake (in_ready depends on alu_op/funct)
//   alu_op, funct           fields to decode
//   out_valid/out_ready     result handshake
//   alu_ctrl, jr, illegal   registered decode result
//   md_start, md_op         one-cycle HI/LO launch pulse and its op
//   md_busy, md_done        HI/LO occupancy and completion pulse
//   stall_cycles            interlock stall count
// Build option: ALU_CTRL_STALL_CNT_EN enables the saturating stall counter;
// without it stall_cycles is tied to 0.
//
// state | meaning
// IDLE  | no HI/LO op in flight
// BUSY  | HI/LO op occupying the unit, counter counting down to 0
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int FUNCT_W = 6,
  parameter int MD_LAT  = 32,
  parameter int CNT_W   = $clog2(MD_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_ctrl,
  output logic               jr,
  output logic               illegal,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_busy,
  output logic               md_done,
  output logic [31:0]        stall_cycles
);

  logic [2:0] dec_alu_ctrl;
  logic       dec_jr, dec_illegal, dec_is_md, dec_is_mf;
  logic [1:0] dec_md_op;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .jr       (dec_jr),
    .illegal  (dec_illegal),
    .is_md    (dec_is_md),
    .is_mf    (dec_is_mf),
    .md_op    (dec_md_op)
  );

  md_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic       jr_q, jr_d;
  logic       illegal_q, illegal_d;
  logic       md_start_q, md_start_d;
  logic [1:0] md_op_q, md_op_d;
  logic       md_done_q, md_done_d;

  logic hazard, accept;

  assign md_busy  = (state_q == BUSY);
  assign hazard   = (dec_is_md || dec_is_mf) && md_busy;
  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    jr_d        = jr_q;
    illegal_d   = illegal_q;
    md_op_d     = md_op_q;
    md_start_d  = 1'b0;
    md_done_d   = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      alu_ctrl_d  = dec_alu_ctrl;
      jr_d        = dec_jr;
      illegal_d   = dec_illegal;
      if (dec_is_md) begin
        md_start_d = 1'b1;
        md_op_d    = dec_md_op;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // hazard keeps HI/LO ops out while BUSY, so accepting one implies IDLE
        if (accept && dec_is_md) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      jr_q        <= 1'b0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= '0;
      md_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      jr_q        <= jr_d;
      illegal_q   <= illegal_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      md_done_q   <= md_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign jr        = jr_q;
  assign illegal   = illegal_q;
  assign md_start  = md_start_q;
  assign md_op     = md_op_q;
  assign md_done   = md_done_q;

`ifdef ALU_CTRL_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
